// File: rtl/mux8way_scanner.sv
// rtl/mux8way_scanner.sv - sequential 8-to-1 collector with valid/ready output.
// Optional parity output enabled by MUX8WAY_SCANNER_PARITY_EN.
module mux8way_scanner #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [7:0]       mask,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] e,
  input  logic [WIDTH-1:0] f,
  input  logic [WIDTH-1:0] g,
  input  logic [WIDTH-1:0] h,
  input  logic             ready,
  output logic [WIDTH-1:0] out,
  output logic [2:0]       sel,
  output logic             valid,
  output logic             busy,
  output logic             done
`ifdef MUX8WAY_SCANNER_PARITY_EN
  ,
  output logic             parity
`endif
);

  typedef enum logic [1:0] {IDLE, SCAN, HOLD, DONE} state_t;

  state_t           state;
  logic [7:0]       pending;
  logic [2:0]       k;
  logic [WIDTH-1:0] chan [8];

  assign chan[0] = a;
  assign chan[1] = b;
  assign chan[2] = c;
  assign chan[3] = d;
  assign chan[4] = e;
  assign chan[5] = f;
  assign chan[6] = g;
  assign chan[7] = h;

  // Scanning downwards leaves the lowest set bit as the final winner.
  function automatic logic [2:0] lowest_set(input logic [7:0] p);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (p[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  always_comb k = lowest_set(pending);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      pending <= 8'd0;
      out     <= '0;
      sel     <= 3'd0;
      valid   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef MUX8WAY_SCANNER_PARITY_EN
      parity  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (mask != 8'd0) begin
              pending <= mask;
              state   <= SCAN;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        SCAN: begin
          out        <= chan[k];
          sel        <= k;
          pending[k] <= 1'b0;
          valid      <= 1'b1;
`ifdef MUX8WAY_SCANNER_PARITY_EN
          parity     <= ^chan[k];
`endif
          state      <= HOLD;
        end
        HOLD: begin
          // pending already excludes the word being held
          if (ready) begin
            valid <= 1'b0;
            if (pending == 8'd0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= SCAN;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
